alu_sm_seq: RTL and testbench

Parametrised sequential sign-magnitude ALU, the next generation of the team's 16-bit arithmetic unit. Operands and results are W-bit sign-magnitude words. The block performs add, subtract, multiply, divide, negate, absolute value and integer square root. Multiply, divide and square root run as multi-cycle iterative engines behind a valid/ready handshake, so the block sits between an operand-issuing controller and a result consumer that may apply backpressure.

---
 rtl/alu_sm_seq_if.sv | 47 ++++
 rtl/alu_sm_seq.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_alu_sm_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sm_seq_if.sv
// Request/result bus for the sequential sign-magnitude ALU.
// master = operand issuer and result consumer, slave = the ALU.
`timescale 1ns/1ps

interface alu_sm_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         dz;
    logic         inv;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  ovf,
        input  dz,
        input  inv
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output ovf,
        output dz,
        output inv
    );
endinterface

// File: rtl/alu_sm_seq.sv
// Sequential sign-magnitude ALU: 1-cycle add/sub/neg/abs/zero, iterative mul/div/sqrt.
// Define ALU_SM_SQRT_EN to build the square-root engine; otherwise op 111 reports inv.
`timescale 1ns/1ps

module alu_sm_seq #(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_sm_seq_if.slave io_bus
);
    localparam int M  = W - 1;
    localparam int CW = $clog2(M + 1);
`ifdef ALU_SM_SQRT_EN
    localparam int N  = (M + 1) / 2;
    localparam int RW = 2 * N;
    localparam logic [CW-1:0] C_SQRT = CW'(N);
`endif
    localparam logic [CW-1:0] C_ITER = CW'(M);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_NEG  = 3'b101;
    localparam logic [2:0] OP_ABS  = 3'b110;
    localparam logic [2:0] OP_SQRT = 3'b111;

    localparam logic [M-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Pack a sign and magnitude, forcing a zero magnitude to +0.
    function automatic logic [W-1:0] f_pack(
        input logic         s,
        input logic [M-1:0] m
    );
        return {s & (|m), m};
    endfunction

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]     r_op;
    logic           r_neg;
    logic [M-1:0]   r_ma;
    logic [M-1:0]   r_mb;
    logic [2*M:0]   r_p;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_result;
    logic           r_ovf;
    logic           r_dz;
    logic           r_inv;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_sa;
    logic           w_sb;
    logic           w_sbe;
    logic [M-1:0]   w_ma;
    logic [M-1:0]   w_mb;
    logic           w_as_sign;
    logic [M:0]     w_as_mag;
    logic           w_multi;
    logic [W-1:0]   w_fast_res;
    logic           w_fast_ovf;
    logic           w_fast_dz;
    logic           w_fast_inv;

    logic [M:0]     w_mul_sum;
    logic [2*M-1:0] w_mul_nxt;
    logic [M:0]     w_div_r;
    logic           w_div_ge;
    logic [M:0]     w_div_rem;
    logic [2*M:0]   w_div_nxt;
    logic [W-1:0]   w_eng_res;
    logic           w_eng_ovf;

`ifdef ALU_SM_SQRT_EN
    logic [RW-1:0]  r_rad;
    logic [N-1:0]   r_root;
    logic [N+2:0]   r_rem;
    logic [N+2:0]   w_sq_sh;
    logic [N+2:0]   w_sq_trial;
    logic           w_sq_ge;
    logic [N+2:0]   w_sq_rem_nxt;
    logic [N-1:0]   w_sq_root_nxt;
`endif

    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = io_bus.in_valid && w_in_ready;

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = (r_state == S_DONE);
    assign io_bus.result    = r_result;
    assign io_bus.ovf       = r_ovf;
    assign io_bus.dz        = r_dz;
    assign io_bus.inv       = r_inv;

    // Operand decode: -0 counts as +0, sub folds into add with b's sign flipped.
    always_comb begin
        w_ma  = io_bus.a[M-1:0];
        w_mb  = io_bus.b[M-1:0];
        w_sa  = io_bus.a[W-1] & (|w_ma);
        w_sb  = io_bus.b[W-1] & (|w_mb);
        w_sbe = w_sb ^ (io_bus.op == OP_SUB);
        w_as_sign = w_sa;
        if (w_sa == w_sbe) begin
            w_as_mag = {1'b0, w_ma} + {1'b0, w_mb};
        end else if (w_ma >= w_mb) begin
            w_as_mag = {1'b0, w_ma - w_mb};
        end else begin
            w_as_mag  = {1'b0, w_mb - w_ma};
            w_as_sign = w_sbe;
        end
    end

    // Single-cycle results and the decision to start an iterative engine.
    always_comb begin
        w_fast_res = '0;
        w_fast_ovf = 1'b0;
        w_fast_dz  = 1'b0;
        w_fast_inv = 1'b0;
        w_multi    = 1'b0;
        case (io_bus.op)
            OP_ADD, OP_SUB: begin
                if (w_as_mag[M]) begin
                    w_fast_res = {w_as_sign, MAG_MAX};
                    w_fast_ovf = 1'b1;
                end else begin
                    w_fast_res = f_pack(w_as_sign, w_as_mag[M-1:0]);
                end
            end
            OP_MUL: w_multi = 1'b1;
            OP_DIV: begin
                if (w_mb == '0) begin
                    w_fast_res = {w_sa, MAG_MAX};
                    w_fast_dz  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_NEG: w_fast_res = f_pack(~w_sa, w_ma);
            OP_ABS: w_fast_res = {1'b0, w_ma};
            OP_SQRT: begin
`ifdef ALU_SM_SQRT_EN
                if (w_sa) begin
                    w_fast_inv = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
`else
                w_fast_inv = 1'b1;
`endif
            end
            OP_ZERO: w_fast_res = '0;
            default: w_fast_res = '0;
        endcase
    end

    // One iteration step of the shift-add multiplier and restoring divider.
    always_comb begin
        w_mul_sum = {1'b0, r_p[2*M-1:M]} + (r_p[0] ? {1'b0, r_ma} : '0);
        w_mul_nxt = {w_mul_sum, r_p[M-1:1]};
        w_div_r   = (r_p[2*M:M] << 1) | {{M{1'b0}}, r_p[M-1]};
        w_div_ge  = (w_div_r >= {1'b0, r_mb});
        w_div_rem = w_div_ge ? (w_div_r - {1'b0, r_mb}) : w_div_r;
        w_div_nxt = {w_div_rem, r_p[M-2:0], w_div_ge};
    end

`ifdef ALU_SM_SQRT_EN
    // One digit of the square root: bring down two radicand bits, try root*4+1.
    always_comb begin
        w_sq_sh       = (r_rem << 2) | {{(N+1){1'b0}}, r_rad[RW-1:RW-2]};
        w_sq_trial    = {1'b0, r_root, 2'b01};
        w_sq_ge       = (w_sq_sh >= w_sq_trial);
        w_sq_rem_nxt  = w_sq_ge ? (w_sq_sh - w_sq_trial) : w_sq_sh;
        w_sq_root_nxt = {r_root[N-2:0], w_sq_ge};
    end
`endif

    // Result of the final engine iteration, including multiply saturation.
    always_comb begin
        w_eng_res = '0;
        w_eng_ovf = 1'b0;
        case (r_op)
            OP_MUL: begin
                if (|w_mul_nxt[2*M-1:M]) begin
                    w_eng_res = {r_neg, MAG_MAX};
                    w_eng_ovf = 1'b1;
                end else begin
                    w_eng_res = f_pack(r_neg, w_mul_nxt[M-1:0]);
                end
            end
            OP_DIV: w_eng_res = f_pack(r_neg, w_div_nxt[M-1:0]);
`ifdef ALU_SM_SQRT_EN
            OP_SQRT: w_eng_res = {1'b0, M'(w_sq_root_nxt)};
`endif
            default: w_eng_res = '0;
        endcase
    end

    // Next-state logic: fast ops go straight to DONE, engines pass through BUSY.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (r_cnt == C_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, engine iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_ZERO;
            r_neg    <= 1'b0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= io_bus.op;
                        r_neg <= w_sa ^ w_sb;
                        r_ma  <= w_ma;
                        r_mb  <= w_mb;
                        r_p   <= {{(M+1){1'b0}},
                                  (io_bus.op == OP_MUL) ? w_mb : w_ma};
                        if (w_multi) begin
`ifdef ALU_SM_SQRT_EN
                            r_cnt <= (io_bus.op == OP_SQRT) ? C_SQRT : C_ITER;
`else
                            r_cnt <= C_ITER;
`endif
                        end else begin
                            r_result <= w_fast_res;
                            r_ovf    <= w_fast_ovf;
                            r_dz     <= w_fast_dz;
                            r_inv    <= w_fast_inv;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - C_ONE;
                    if (r_op == OP_MUL) begin
                        r_p <= {1'b0, w_mul_nxt};
                    end else begin
                        r_p <= w_div_nxt;
                    end
                    if (r_cnt == C_ONE) begin
                        r_result <= w_eng_res;
                        r_ovf    <= w_eng_ovf;
                        r_dz     <= 1'b0;
                        r_inv    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ALU_SM_SQRT_EN
    // Square-root engine registers: radicand shifter, partial root, remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_rad  <= RW'(w_ma);
            r_root <= '0;
            r_rem  <= '0;
        end else if (r_state == S_BUSY && r_op == OP_SQRT) begin
            r_rad  <= r_rad << 2;
            r_root <= w_sq_root_nxt;
            r_rem  <= w_sq_rem_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sm_seq.sv
// Randomised bench for alu_sm_seq against an integer-arithmetic reference model.
// Pinned test-plan vectors anchor the model; a monitor checks outputs every valid cycle.
`timescale 1ns/1ps

module tb_alu_sm_seq;
    localparam int W = 16;
    localparam int M = W - 1;
    localparam longint MAXM = (64'd1 << M) - 1;

    localparam logic [2:0] ZERO = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] MUL  = 3'b011;
    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] NEG  = 3'b101;
    localparam logic [2:0] ABS  = 3'b110;
    localparam logic [2:0] SQRT = 3'b111;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   run_cmp  = 0;
    bit   exp_pending = 0;
    logic [W-1:0] exp_res;
    logic [2:0]   exp_flags;

    alu_sm_seq_if #(.W(W)) bus ();

    alu_sm_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] enc(input longint v);
        logic [M-1:0] m;
        longint av;
        av = (v < 0) ? -v : v;
        m  = M'(av);
        if (v == 0) return '0;
        return {(v < 0), m};
    endfunction

    // Reference: plain signed integer arithmetic with saturation.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic [2:0] flags, output int lat);
        longint va, vb, v, x, av;
        logic fo, fd, fi;
        va = a[W-1] ? -longint'(a[M-1:0]) : longint'(a[M-1:0]);
        vb = b[W-1] ? -longint'(b[M-1:0]) : longint'(b[M-1:0]);
        fo = 0; fd = 0; fi = 0; lat = 1; v = 0;
        case (o)
            ADD: v = va + vb;
            SUB: v = va - vb;
            MUL: begin v = va * vb; lat = 1 + M; end
            DIV: begin
                if (vb == 0) fd = 1;
                else begin v = va / vb; lat = 1 + M; end
            end
            NEG: v = -va;
            ABS: v = (va < 0) ? -va : va;
            SQRT: begin
`ifdef ALU_SM_SQRT_EN
                if (va < 0) fi = 1;
                else begin
                    x = 0;
                    while ((x + 1) * (x + 1) <= va) x++;
                    v = x;
                    lat = 1 + (M + 1) / 2;
                end
`else
                fi = 1;
`endif
            end
            default: v = 0;
        endcase
        av = (v < 0) ? -v : v;
        if (fd) r = {(va < 0), M'(MAXM)};
        else if (av > MAXM) begin r = {(v < 0), M'(MAXM)}; fo = 1; end
        else r = enc(v);
        flags = {fo, fd, fi};
    endfunction

    // Monitor: while a result is owed, every valid cycle must show it; else no valid.
    always @(negedge clk) begin
        if (run_cmp) begin
            if (exp_pending) begin
                if (bus.out_valid) begin
                    check("result", bus.result, exp_res);
                    check("flags", {bus.ovf, bus.dz, bus.inv}, exp_flags);
                end
            end else begin
                check("no_spurious_valid", bus.out_valid, 0);
            end
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input bit pin,
                       input logic [W-1:0] pin_res, input logic [2:0] pin_flags);
        logic [W-1:0] mr;
        logic [2:0]   mf;
        int lat;
        int k;
        model(o, a, b, mr, mf, lat);
        if (pin) begin
            check("model_res", mr, pin_res);
            check("model_flags", mf, pin_flags);
        end
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        exp_res = mr;
        exp_flags = mf;
        exp_pending = 1;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = a;
        bus.b = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!bus.out_valid) begin
                check("in_ready_busy", bus.in_ready, 0);
                bus.in_valid = 1'($urandom);
            end
        end while (!bus.out_valid && k < 200);
        check("latency", k, lat);
        check("in_ready_done", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", bus.in_ready, 1);
        check("post_hs_valid", bus.out_valid, 0);
        exp_pending = 0;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [M-1:0] m;
        case ($urandom_range(0, 4))
            0: m = '0;
            1: m = M'(1);
            2: m = M'(MAXM);
            3: m = M'($urandom_range(0, 255));
            default: m = M'($urandom_range(0, 32'(MAXM)));
        endcase
        return {1'($urandom), m};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = ZERO;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_rst", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.ovf, bus.dz, bus.inv}, 0);
        run_cmp = 1;

        run(ADD, 16'h0064, 16'h801E, 0, 1, 16'h0046, 3'b000);
        run(ADD, 16'h7FFF, 16'h0001, 1, 1, 16'h7FFF, 3'b100);
        run(SUB, 16'h8005, 16'h8005, 0, 1, 16'h0000, 3'b000);
        run(MUL, 16'h8003, 16'h0005, 3, 1, 16'h800F, 3'b000);
        run(DIV, 16'h0007, 16'h8002, 0, 1, 16'h8003, 3'b000);
        run(DIV, 16'h8007, 16'h0000, 2, 1, 16'hFFFF, 3'b010);
`ifdef ALU_SM_SQRT_EN
        run(SQRT, 16'h0051, 16'h0000, 0, 1, 16'h0009, 3'b000);
        run(SQRT, 16'h7FFF, 16'h0000, 1, 1, 16'h00B5, 3'b000);
`else
        run(SQRT, 16'h0051, 16'h0000, 0, 1, 16'h0000, 3'b001);
`endif
        run(SQRT, 16'h8004, 16'h0000, 0, 1, 16'h0000, 3'b001);
        run(NEG, 16'h0000, 16'h1234, 0, 1, 16'h0000, 3'b000);
        run(NEG, 16'h0005, 16'h0000, 0, 1, 16'h8005, 3'b000);
        run(ABS, 16'h8005, 16'h0000, 1, 1, 16'h0005, 3'b000);
        run(ZERO, 16'h1234, 16'h5678, 0, 1, 16'h0000, 3'b000);
        run(SUB, 16'h8000, 16'h0003, 0, 1, 16'h8003, 3'b000);
        run(MUL, 16'h0100, 16'h0100, 0, 1, 16'h7FFF, 3'b100);
        run(DIV, 16'h0003, 16'h0007, 0, 1, 16'h0000, 3'b000);
        run(DIV, 16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 3'b000);

        // Abort a divide with reset at t+5 after accept.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = DIV;
        bus.a = 16'h0064;
        bus.b = 16'h0003;
        exp_res = 16'h0021;
        exp_flags = 3'b000;
        exp_pending = 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_pending = 0;
        @(negedge clk);
        check("abort_in_ready_rst", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_result", bus.result, 0);
        check("abort_flags", {bus.ovf, bus.dz, bus.inv}, 0);
        repeat (20) @(negedge clk);
        run(ADD, 16'h0010, 16'h0020, 0, 1, 16'h0030, 3'b000);

        for (int n = 0; n < 80; n++) begin
            ra = rnd_word();
            rb = rnd_word();
            run(3'($urandom), ra, rb, $urandom_range(0, 3), 0, '0, '0);
        end

        run_cmp = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
